// File: rtl/axi4_lite_reg_bank_if.sv
// Request/response interface between the AXI4-Lite slave front end and the register bank.
// Handshake: send_slave_write/read are one-cycle request pulses accepted only while the bank is idle; each accepted request returns exactly one write_done/read_done pulse with slave_resp (and slave_rdata for reads) valid in that cycle.
interface axi4_lite_reg_bank_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0]  slave_addr;
  logic [DATA_WIDTH-1:0]     slave_wdata;
  logic [DATA_WIDTH/8-1:0]   slave_wstrb;
  logic                      send_slave_write;
  logic                      send_slave_read;
  logic [DATA_WIDTH-1:0]     slave_rdata;
  logic                      slave_write_done;
  logic                      slave_read_done;
  logic [1:0]                slave_resp;

  modport master (
    output slave_addr, slave_wdata, slave_wstrb, send_slave_write, send_slave_read,
    input  slave_rdata, slave_write_done, slave_read_done, slave_resp
  );

  modport slave (
    input  slave_addr, slave_wdata, slave_wstrb, send_slave_write, send_slave_read,
    output slave_rdata, slave_write_done, slave_read_done, slave_resp
  );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// Register bank with NUM_REGS-1 control registers and one read-only status register,
// completing each request after WAIT_CYCLES programmable wait states.
module axi4_lite_reg_bank #(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       NUM_REGS      = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       WAIT_CYCLES   = 1
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  axi4_lite_reg_bank_if.slave                bus,
  input  logic [DATA_WIDTH-1:0]              status_in,
  output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] reg_out
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDXW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NCTRL = NUM_REGS - 1;
  localparam logic [ADDRESS_WIDTH-1:0] NUM_REGS_A = ADDRESS_WIDTH'(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [BYTES-1:0]         wstrb_q, wstrb_d;
  logic                     is_write_q, is_write_d;
  logic                     pending_read_q, pending_read_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     write_done_q, write_done_d;
  logic                     read_done_q, read_done_d;
  logic [1:0]               resp_q, resp_d;
  logic [DATA_WIDTH-1:0]    regs_q [NCTRL];
  logic [DATA_WIDTH-1:0]    regs_d [NCTRL];

  logic [ADDRESS_WIDTH-1:0] acc_addr, offset, index;
  logic [DATA_WIDTH-1:0]    acc_wdata, rd_val;
  logic [BYTES-1:0]         acc_wstrb;
  logic                     acc_write, in_range, is_status;
  logic [IDXW-1:0]          idx;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    is_write_d     = is_write_q;
    pending_read_d = pending_read_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    resp_d         = resp_q;
    regs_d         = regs_q;
    write_done_d   = 1'b0;
    read_done_d    = 1'b0;

    // In IDLE with WAIT_CYCLES=0 the access executes on the capture edge, so use the bus directly.
    acc_addr  = (state_q == S_IDLE) ? bus.slave_addr  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? bus.slave_wdata : wdata_q;
    acc_wstrb = (state_q == S_IDLE) ? bus.slave_wstrb : wstrb_q;
    case (state_q)
      S_IDLE:  acc_write = bus.send_slave_write;
      S_WAIT:  acc_write = is_write_q;
      default: acc_write = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.send_slave_write || bus.send_slave_read) begin
          addr_d         = bus.slave_addr;
          wdata_d        = bus.slave_wdata;
          wstrb_d        = bus.slave_wstrb;
          is_write_d     = bus.send_slave_write;
          pending_read_d = bus.send_slave_write && bus.send_slave_read;
          cnt_d          = WAIT_LOAD;
          state_d        = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      default: begin
        if (pending_read_q) begin
          // The held read restarts with full latency at the captured address.
          pending_read_d = 1'b0;
          is_write_d     = 1'b0;
          cnt_d          = WAIT_LOAD;
          state_d        = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    offset    = acc_addr - BASE_ADDR;
    index     = offset >> SHIFT;
    in_range  = (acc_addr >= BASE_ADDR) && (index < NUM_REGS_A);
    idx       = index[IDXW-1:0];
    is_status = (idx == IDXW'(NCTRL));

    rd_val = '0;
    if (in_range && is_status) rd_val = status_in;
    for (int r = 0; r < NCTRL; r++) begin
      if (in_range && idx == IDXW'(r)) rd_val = regs_q[r];
    end

    if (state_d == S_RESP) begin
      if (acc_write) begin
        write_done_d = 1'b1;
        if (!in_range)      resp_d = 2'b11;
        else if (is_status) resp_d = 2'b10;
        else begin
          resp_d = 2'b00;
          for (int r = 0; r < NCTRL; r++) begin
            if (idx == IDXW'(r)) begin
              for (int b = 0; b < BYTES; b++) begin
                if (acc_wstrb[b]) regs_d[r][8*b +: 8] = acc_wdata[8*b +: 8];
              end
            end
          end
        end
      end else begin
        read_done_d = 1'b1;
        resp_d      = in_range ? 2'b00 : 2'b11;
        rdata_d     = rd_val;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      is_write_q     <= 1'b0;
      pending_read_q <= 1'b0;
      cnt_q          <= '0;
      rdata_q        <= '0;
      write_done_q   <= 1'b0;
      read_done_q    <= 1'b0;
      resp_q         <= 2'b00;
      for (int r = 0; r < NCTRL; r++) regs_q[r] <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      is_write_q     <= is_write_d;
      pending_read_q <= pending_read_d;
      cnt_q          <= cnt_d;
      rdata_q        <= rdata_d;
      write_done_q   <= write_done_d;
      read_done_q    <= read_done_d;
      resp_q         <= resp_d;
      regs_q         <= regs_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int r = 0; r < NCTRL; r++) reg_out[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
  end

  assign bus.slave_rdata      = rdata_q;
  assign bus.slave_write_done = write_done_q;
  assign bus.slave_read_done  = read_done_q;
  assign bus.slave_resp       = resp_q;
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed bench for axi4_lite_reg_bank: WAIT_CYCLES=3, eight 32-bit registers at 0x1000.
module tb_axi4_lite_reg_bank;
  localparam int          W    = 3;
  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          WIN  = 2 * W + 6;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [31:0]  status_in = '0;
  logic [223:0] reg_out;
  logic [223:0] exp_regs = '0;

  axi4_lite_reg_bank_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  axi4_lite_reg_bank #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus), .status_in(status_in), .reg_out(reg_out)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  int          wr_cnt, rd_cnt, wr_cyc, rd_cyc;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic        both_hi;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches a fixed window of cycles for completion pulses.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input logic busy);
    @(negedge ACLK);
    bus.send_slave_write = wr;
    bus.send_slave_read  = rd;
    bus.slave_addr       = addr;
    bus.slave_wdata      = wdata;
    bus.slave_wstrb      = strb;
    @(posedge ACLK);
    #1;
    bus.send_slave_write = 1'b0;
    bus.send_slave_read  = 1'b0;
    wr_cnt = 0; rd_cnt = 0; wr_cyc = -1; rd_cyc = -1;
    wr_resp = 2'bxx; rd_resp = 2'bxx; rd_data = 'x; both_hi = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge ACLK);
      if (bus.slave_write_done) begin
        wr_cnt++; wr_cyc = c; wr_resp = bus.slave_resp;
      end
      if (bus.slave_read_done) begin
        rd_cnt++; rd_cyc = c; rd_resp = bus.slave_resp; rd_data = bus.slave_rdata;
      end
      if (bus.slave_write_done && bus.slave_read_done) both_hi = 1'b1;
      if (busy && c == 1) bus.send_slave_read = 1'b1;
      if (busy && c == 2) bus.send_slave_read = 1'b0;
    end
  endtask

  initial begin
    int dones;
    bus.send_slave_write = 1'b0;
    bus.send_slave_read  = 1'b0;
    bus.slave_addr       = '0;
    bus.slave_wdata      = '0;
    bus.slave_wstrb      = '0;

    // Reset defaults
    repeat (3) @(negedge ACLK);
    check("rst_rdata", bus.slave_rdata, 0);
    check("rst_wdone", bus.slave_write_done, 0);
    check("rst_rdone", bus.slave_read_done, 0);
    check("rst_resp", bus.slave_resp, 0);
    check("rst_reg_out", reg_out, 0);
    ARESETn = 1'b1;

    // Populate reg 3 so the mid-access reset has something to clear
    issue(1, 0, BASE + 32'd12, 32'hCAFE_F00D, 4'hF, 0);
    exp_regs[127:96] = 32'hCAFE_F00D;
    check("w3_cycle", wr_cyc, W);
    check("w3_resp", wr_resp, 2'b00);
    check("w3_reg_out", reg_out, exp_regs);
    issue(0, 1, BASE + 32'd12, 0, 0, 0);
    check("r3_cycle", rd_cyc, W);
    check("r3_data", rd_data, 32'hCAFE_F00D);

    // Reset in the middle of a write to reg 1
    @(negedge ACLK);
    bus.send_slave_write = 1'b1;
    bus.slave_addr       = BASE + 32'd4;
    bus.slave_wdata      = 32'h1234_5678;
    bus.slave_wstrb      = 4'hF;
    @(posedge ACLK);
    #1;
    bus.send_slave_write = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    exp_regs = '0;
    check("midrst_rdata", bus.slave_rdata, 0);
    check("midrst_resp", bus.slave_resp, 0);
    check("midrst_reg_out", reg_out, 0);
    check("midrst_done", {bus.slave_write_done, bus.slave_read_done}, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge ACLK);
      if (bus.slave_write_done || bus.slave_read_done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_reg_out_after", reg_out, 0);
    issue(0, 1, BASE + 32'd4, 0, 0, 0);
    check("midrst_r1_data", rd_data, 0);
    check("midrst_r1_resp", rd_resp, 2'b00);

    // Latency of a full-word write to reg 1
    issue(1, 0, BASE + 32'd4, 32'hDEAD_BEEF, 4'hF, 0);
    exp_regs[63:32] = 32'hDEAD_BEEF;
    check("lat_cycle", wr_cyc, W);
    check("lat_count", {wr_cnt[7:0], rd_cnt[7:0]}, 16'h0100);
    check("lat_resp", wr_resp, 2'b00);
    check("lat_reg_out", reg_out, exp_regs);

    // Byte strobes on reg 2
    issue(1, 0, BASE + 32'd8, 32'h1122_3344, 4'hF, 0);
    issue(1, 0, BASE + 32'd8, 32'hAABB_CCDD, 4'b0101, 0);
    exp_regs[95:64] = 32'h11BB_33DD;
    check("strb_reg_out", reg_out, exp_regs);
    issue(0, 1, BASE + 32'd8, 0, 0, 0);
    check("strb_rdata", rd_data, 32'h11BB_33DD);

    // Out-of-range, underflow, status and zero-strobe cases
    issue(0, 1, BASE + 32'd4 * NR, 0, 0, 0);
    check("oor_resp", rd_resp, 2'b11);
    check("oor_rdata", rd_data, 0);
    issue(0, 1, BASE - 32'd4, 0, 0, 0);
    check("under_resp", rd_resp, 2'b11);
    issue(1, 0, BASE + 32'd28, 32'hFFFF_FFFF, 4'hF, 0);
    check("stw_resp", wr_resp, 2'b10);
    check("stw_reg_out", reg_out, exp_regs);
    status_in = 32'h0000_CAFE;
    issue(0, 1, BASE + 32'd28, 0, 0, 0);
    check("str_rdata", rd_data, 32'h0000_CAFE);
    check("str_resp", rd_resp, 2'b00);
    issue(1, 0, BASE + 32'd4, 32'h0000_0000, 4'h0, 0);
    check("zstrb_resp", wr_resp, 2'b00);
    check("zstrb_reg_out", reg_out, exp_regs);
    issue(0, 1, BASE + 32'd7, 0, 0, 0);
    check("unaligned_rdata", rd_data, 32'hDEAD_BEEF);
    issue(1, 0, BASE + 32'd64, 32'h1, 4'hF, 0);
    check("oor_w_resp", wr_resp, 2'b11);
    check("oor_w_reg_out", reg_out, exp_regs);

    // Simultaneous write and read of reg 0
    issue(1, 1, BASE, 32'h5A5A_5A5A, 4'hF, 0);
    exp_regs[31:0] = 32'h5A5A_5A5A;
    check("sim_wr_cycle", wr_cyc, W);
    check("sim_rd_cycle", rd_cyc, 2 * W + 1);
    check("sim_counts", {wr_cnt[7:0], rd_cnt[7:0]}, 16'h0101);
    check("sim_rdata", rd_data, 32'h5A5A_5A5A);
    check("sim_both_hi", both_hi, 0);
    check("sim_reg_out", reg_out, exp_regs);

    // Request arriving while busy is dropped
    issue(0, 1, BASE, 0, 0, 1);
    check("busy_counts", {wr_cnt[7:0], rd_cnt[7:0]}, 16'h0001);
    check("busy_rd_cycle", rd_cyc, W);
    check("busy_rdata", rd_data, 32'h5A5A_5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_lite_reg_bank.md
Name: axi4_lite_reg_bank

Overview:
Register-bank peripheral that sits directly downstream of the AXI4-Lite slave and consumes its request interface: send_slave_write/send_slave_read, slave_addr, slave_wdata and slave_wstrb.
It completes each request after a programmable wait-state count and returns slave_write_done/slave_read_done, slave_resp and slave_rdata.
It holds NUM_REGS-1 read/write control registers plus one read-only status register.
Control register contents are exported to the rest of the SoC.

Parameters:
DATA_WIDTH, 32, register and data bus width; must be 32 or 64.
ADDRESS_WIDTH, 32, request address width.
NUM_REGS, 8, total registers including status; range 2..256.
BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8.
WAIT_CYCLES, 1, extra wait states per access; range 0..15.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
slave_addr  in  ADDRESS_WIDTH  byte address of request
slave_wdata  in  DATA_WIDTH  write data
slave_wstrb  in  DATA_WIDTH/8  byte write strobes
send_slave_write  in  1  write request pulse
send_slave_read  in  1  read request pulse
slave_rdata  out  DATA_WIDTH  read data
slave_write_done  out  1  write completion pulse
slave_read_done  out  1  read completion pulse
slave_resp  out  2  response code
status_in  in  DATA_WIDTH  value returned by status register (index NUM_REGS-1)
reg_out  out  (NUM_REGS-1)*DATA_WIDTH  flattened control registers; reg 0 in LSBs

Behaviour:
- Reset: one clock (ACLK); reset is asynchronous and active-low (ARESETn). While ARESETn is low, all outputs are 0: slave_rdata, both done signals, slave_resp=2'b00, reg_out, FSM=IDLE, pending flag clear.
- Reset asserted mid-access aborts the access: no done pulse, no register update.
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is sampled on a rising edge with send_slave_write or send_slave_read high. On that edge addr/wdata/wstrb are captured and the wait counter is loaded with WAIT_CYCLES.
  - If WAIT_CYCLES=0, the FSM goes straight to RESP; otherwise it goes to WAIT.
- WAIT: the counter decrements each cycle; at 1 the FSM moves to RESP on the next edge.
- RESP: exactly one cycle with the matching done signal high. slave_resp is valid in the same cycle.
  - Next state is IDLE, or WAIT/RESP for a pending read (see simultaneous requests below).
- Latency: done asserts WAIT_CYCLES+1 cycles after the request edge. Throughput is one access per WAIT_CYCLES+2 cycles.
- Requests seen while not in IDLE are ignored and produce no done. Upstream guarantees one outstanding request.
- Simultaneous send_slave_write and send_slave_read in IDLE:
  - The write is served first at the captured address.
  - The read is held pending and then served at the same address with full wait-state latency; it returns the newly written data.
  - Two done pulses result, write first.
- Address decode:
  - offset = slave_addr - BASE_ADDR, computed in ADDRESS_WIDTH bits so it wraps on underflow.
  - index = offset >> log2(DATA_WIDTH/8). Unaligned low bits are ignored.
  - offset underflow or index >= NUM_REGS gives an out-of-range access.
- Responses:
  - OKAY 2'b00.
  - Out-of-range access: DECERR 2'b11.
  - Write to the status register: SLVERR 2'b10.
  - slave_resp holds its value until the next RESP.
- Writes: on the edge entering RESP, for each byte i with wstrb[i]=1, reg[index] byte i = wdata byte i. Other bytes are unchanged.
  - No register changes on DECERR, SLVERR or all-zero wstrb. All-zero wstrb still returns OKAY.
- Reads: slave_rdata is loaded on the edge entering RESP and held until the next read completes.
  - Index NUM_REGS-1 returns status_in as sampled on that edge.
  - DECERR returns 0.
- reg_out updates on the same edge the write takes effect; no further delay.
- Done signals are never high outside RESP and are never both high in the same cycle.

Test Plan:
- Reset/defaults: assert ARESETn low mid-WAIT of a write to reg 1 -> no done pulse, reg_out=0, outputs 0; after release, read reg 1 -> rdata=0, resp=00.
- Latency: WAIT_CYCLES=3, write 0xDEADBEEF to BASE_ADDR+4 with wstrb=4'hF -> write_done high exactly 4 cycles after the request edge, resp=00, reg_out[63:32]=0xDEADBEEF.
- Byte strobes: reg 2 = 0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
- Errors: read BASE_ADDR+4*NUM_REGS -> resp=11, rdata=0; write status address -> resp=10, no reg_out change; read status with status_in=0x0000CAFE -> 0x0000CAFE, resp=00.
- Simultaneous write+read of reg 0 with wdata=0x5A5A5A5A -> write_done pulse, then read_done pulse WAIT_CYCLES+1 cycles later with rdata=0x5A5A5A5A.
- Busy-time request: pulse send_slave_read during WAIT -> ignored, exactly one done for the original access.
